system_top: RTL and testbench
=============================

// Module: system_top
//
// PURPOSE
//  Arty board-level top: one clock domain hosting a UART command/echo
//  console, a 4-bit LED register and a 4-bit DIP-switch input.
//  After reset it sends a prompt byte, echoes host bytes, lets the host
//  set the LEDs and read the switches. Pins connect straight to the board.
//
// PARAMETERS
//  CLKS_PER_BIT  868   sys_clock cycles per UART bit (100 MHz / 115200); >= 4
//  PROMPT        8'h3E byte sent once after each reset release ('>')
//
// PORTS
//  sys_clock                 in     1  system clock, all logic rising-edge
//  reset                     in     1  synchronous, active-high reset
//  dip_switches_4bits_tri_i  in     4  board DIP switches, asynchronous
//  led_4bits_tri_io          inout  4  board LEDs; always driven, never Z
//  usb_uart_rxd              in     1  UART RX from host, idle high, async
//  usb_uart_txd              out    1  UART TX to host, idle high
//
// BEHAVIOUR
//  Reset (sampled on sys_clock while reset=1):
//  - usb_uart_txd=1, led register=4'h0, RX/TX idle, holding reg empty,
//    prompt pending set. Mid-frame reset aborts TX; txd high next cycle.
//  Input sync: dip switches and rxd pass 2-FF synchronisers (rxd FFs
//    reset to 1). All decisions use synchronised values.
//  LEDs: led_4bits_tri_io = led register, output enable permanently on.
//  UART frame: 8N1, LSB first, CLKS_PER_BIT cycles per bit, no parity.
//  RX:
//  - idle -> start on synced rxd falling edge; re-sample at
//    CLKS_PER_BIT/2; if high, false start, back to idle.
//  - 8 data bits sampled at bit centres; stop bit sampled at centre.
//  - stop=1: one-cycle rx_valid with byte. stop=0: framing error,
//    byte discarded, wait for rxd=1 before re-arming.
//  Command decode (cycle after rx_valid):
//  - byte 8'h40..8'h4F: led register <= byte[3:0]; byte also echoed.
//  - byte 8'h3F ('?'): no echo; reply 8'h30 + {4'b0, synced switches}.
//  - any other byte: echoed unchanged.
//  TX path: one-entry holding register in front of the transmitter.
//  - response loads holding reg; TX takes it when idle; txd start bit
//    begins <= 3 cycles after rx_valid when TX idle.
//  - holding reg full when new response arrives: new response dropped
//    (LED update still applied). No other back-pressure.
//  - TX: start(0), d0..d7, stop(1), each exactly CLKS_PER_BIT cycles;
//    next frame may start the cycle after stop bit ends.
//  Prompt: first cycle after reset deasserts, PROMPT is queued and sent
//    before any echo; RX runs concurrently, responses wait in holding reg.
//  RX and TX fully independent; full-duplex traffic supported.
//
// TESTING  (CLKS_PER_BIT=8 for simulation)
//  - reset high 5 cycles, release -> txd=1 during reset, then one frame
//    0x3E (bits 0,0,1,1,1,1,1,0,0,1 incl. start/stop), then txd idle 1.
//  - send 'A'(0x41) on rxd after prompt -> LEDs=4'h1, txd echoes 0x41.
//  - switches=4'hA, send 0x3F -> txd sends 0x3A, no echo, LEDs unchanged.
//  - rxd low for 2 cycles only -> no byte, no TX activity, LEDs unchanged.
//  - frame 0x55 with stop=0 -> discarded; next valid 0x4F -> LEDs=4'hF,
//    echo 0x4F.
//  - assert reset mid-echo frame -> txd=1 next cycle, LEDs=0, prompt
//    0x3E re-sent after release.

Source files
------------

// File: rtl/system_top.sv
// system_top -- Arty board-level top, single sys_clock domain.
//
// Hosts a UART console (8N1, LSB first), a 4-bit LED register and a 4-bit
// DIP-switch input.
// - After each reset release a PROMPT byte is sent.
// - Host bytes 8'h40..8'h4F set the LED register from the low nibble and are
//   echoed back.
// - Byte '?' (8'h3F) is answered with 8'h30 + switches and is not echoed.
// - Every other byte is echoed unchanged.
//
// Ports:
//   sys_clock                 in     1  system clock, rising edge
//   reset                     in     1  synchronous, active-high
//   dip_switches_4bits_tri_i  in     4  DIP switches (asynchronous)
//   led_4bits_tri_io          inout  4  LEDs, always driven
//   usb_uart_rxd              in     1  UART RX from host (asynchronous, idle 1)
//   usb_uart_txd              out    1  UART TX to host (idle 1)
//
// Handshake: rx_valid is a one-cycle strobe with no ready. A response is
// accepted into the one-entry holding register only if that register is
// empty, or is being emptied by the transmitter in the same cycle. Otherwise
// the response is dropped. The transmitter pulls from the holding register
// whenever it is idle and no prompt is pending.
module system_top #(
  parameter int         CLKS_PER_BIT = 868,
  parameter logic [7:0] PROMPT       = 8'h3E
) (
  input  logic       sys_clock,
  input  logic       reset,
  input  logic [3:0] dip_switches_4bits_tri_i,
  inout  wire  [3:0] led_4bits_tri_io,
  input  logic       usb_uart_rxd,
  output logic       usb_uart_txd
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP
  } tx_state_t;

  // Input synchronisers. The rxd flops reset to the idle level so that
  // leaving reset cannot fake a start bit.
  logic [3:0] dip_s1, dip_s2;
  logic       rx_s1, rx_s2, rx_prev;

  rx_state_t  rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0] rx_bit;
  logic [7:0] rx_shift;
  logic [7:0] rx_data;
  logic       rx_valid;

  tx_state_t  tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0] tx_bit;
  logic [7:0] tx_shift;

  logic [3:0] led_reg;
  logic [7:0] hold;
  logic       hold_full;
  logic       prompt_pending;

  logic [7:0] resp;
  logic       hold_take;

  assign led_4bits_tri_io = led_reg;

  always_ff @(posedge sys_clock) begin
    if (reset) begin
      dip_s1  <= 4'h0;
      dip_s2  <= 4'h0;
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      dip_s1  <= dip_switches_4bits_tri_i;
      dip_s2  <= dip_s1;
      rx_s1   <= usb_uart_rxd;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // Receiver: the start bit is re-checked at its centre, and every later bit
  // is sampled one full bit period after the previous sample.
  always_ff @(posedge sys_clock) begin
    if (reset) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= 3'd0;
      rx_shift <= 8'h00;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          if (rx_prev && !rx_s2) rx_state <= RX_START;
        end
        RX_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_bit   <= 3'd0;
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt <= '0;
            if (rx_s2) begin
              rx_data  <= rx_shift;
              rx_valid <= 1'b1;
              rx_state <= RX_IDLE;
            end else begin
              // Framing error: drop the byte and wait for the line to idle.
              rx_state <= RX_WAIT_HIGH;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_WAIT_HIGH: begin
          if (rx_s2) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  always_comb begin
    resp = rx_data;
    if (rx_data == 8'h3F) resp = 8'h30 + {4'b0000, dip_s2};
  end

  // The holding register empties only when the idle transmitter has no
  // prompt to send first.
  assign hold_take = (tx_state == TX_IDLE) && !prompt_pending && hold_full;

  // Command decode, holding register and transmitter.
  always_ff @(posedge sys_clock) begin
    if (reset) begin
      led_reg        <= 4'h0;
      hold           <= 8'h00;
      hold_full      <= 1'b0;
      prompt_pending <= 1'b1;
      tx_state       <= TX_IDLE;
      tx_cnt         <= '0;
      tx_bit         <= 3'd0;
      tx_shift       <= 8'h00;
      usb_uart_txd   <= 1'b1;
    end else begin
      if (hold_take) hold_full <= 1'b0;
      if (rx_valid) begin
        if (rx_data[7:4] == 4'h4) led_reg <= rx_data[3:0];
        if (!hold_full || hold_take) begin
          hold      <= resp;
          hold_full <= 1'b1;
        end
      end

      case (tx_state)
        TX_IDLE: begin
          tx_cnt       <= '0;
          usb_uart_txd <= 1'b1;
          if (prompt_pending) begin
            prompt_pending <= 1'b0;
            tx_shift       <= PROMPT;
            usb_uart_txd   <= 1'b0;
            tx_state       <= TX_START;
          end else if (hold_full) begin
            tx_shift     <= hold;
            usb_uart_txd <= 1'b0;
            tx_state     <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt       <= '0;
            tx_bit       <= 3'd0;
            usb_uart_txd <= tx_shift[0];
            tx_state     <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              usb_uart_txd <= 1'b1;
              tx_state     <= TX_STOP;
            end else begin
              tx_bit       <= tx_bit + 3'd1;
              tx_shift     <= {1'b0, tx_shift[7:1]};
              usb_uart_txd <= tx_shift[1];
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_state <= TX_IDLE;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_system_top.sv
// Directed testbench for system_top with CLKS_PER_BIT = 8.
module tb_system_top;

  localparam int CPB = 8;

  logic       clk;
  logic       reset;
  logic [3:0] dips;
  wire  [3:0] leds;
  logic       rxd;
  logic       txd;

  int checks   = 0;
  int failures = 0;

  system_top #(.CLKS_PER_BIT(CPB), .PROMPT(8'h3E)) dut (
    .sys_clock                (clk),
    .reset                    (reset),
    .dip_switches_4bits_tri_i (dips),
    .led_4bits_tri_io         (leds),
    .usb_uart_rxd             (rxd),
    .usb_uart_txd             (txd)
  );

  // Clock and reset defaults
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard: expected frames are queued before the stimulus that
  // provokes them, and each captured frame is checked against the head.
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive one host frame on rxd, one bit every CPB cycles.
  task automatic send_byte(input logic [7:0] data, input logic stop_bit);
    @(negedge clk);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int b = 0; b < 8; b++) begin
      rxd = data[b];
      repeat (CPB) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
  endtask

  // Wait for a start bit on txd within a bounded number of cycles, then
  // sample each bit at its centre.
  task automatic get_frame(output logic [7:0] data, output logic stop_bit,
                           output logic found);
    int waited;
    data     = 8'h00;
    stop_bit = 1'b0;
    found    = 1'b0;
    waited   = 0;
    while (!found && waited < 400) begin
      @(negedge clk);
      waited++;
      if (txd === 1'b0) found = 1'b1;
    end
    if (found) begin
      repeat (CPB / 2) @(negedge clk);
      for (int b = 0; b < 8; b++) begin
        repeat (CPB) @(negedge clk);
        data[b] = txd;
      end
      repeat (CPB) @(negedge clk);
      stop_bit = txd;
    end
  endtask

  // Capture one frame and score it against the expected queue.
  task automatic expect_frame(input string tag);
    logic [7:0] d;
    logic       s;
    logic       f;
    logic [7:0] e;
    get_frame(d, s, f);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    check({tag, "_found"}, {31'd0, f}, 32'd1);
    check({tag, "_data"}, {24'd0, d}, {24'd0, e});
    check({tag, "_stop"}, {31'd0, s}, 32'd1);
  endtask

  task automatic send_and_expect(input logic [7:0] data, input string tag);
    fork
      send_byte(data, 1'b1);
      expect_frame(tag);
    join
  endtask

  // Count cycles in which txd is not idle-high.
  task automatic expect_idle(input string tag, input int cycles);
    int lows;
    lows = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
    check(tag, lows, 0);
  endtask

  initial begin
    int waited;
    reset = 1'b1;
    dips  = 4'h0;
    rxd   = 1'b1;

    // Reset held for 5 cycles.
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("reset_txd", {31'd0, txd}, 32'd1);
    check("reset_leds", {28'd0, leds}, 32'd0);

    // Prompt after release.
    exp_q.push_back(8'h3E);
    reset = 1'b0;
    expect_frame("prompt");
    expect_idle("idle_after_prompt", 40);

    // 'A' sets LEDs to 1 and is echoed.
    exp_q.push_back(8'h41);
    send_and_expect(8'h41, "echo_A");
    check("leds_after_A", {28'd0, leds}, 32'h1);

    // '?' returns 0x30 + switches, with no echo.
    dips = 4'hA;
    repeat (4) @(negedge clk);
    exp_q.push_back(8'h3A);
    send_and_expect(8'h3F, "query");
    check("leds_after_query", {28'd0, leds}, 32'h1);
    expect_idle("no_echo_query", 60);

    // Two-cycle glitch is a false start.
    @(negedge clk);
    rxd = 1'b0;
    repeat (2) @(negedge clk);
    rxd = 1'b1;
    expect_idle("glitch_idle", 150);
    check("glitch_leds", {28'd0, leds}, 32'h1);

    // 0x55 with a low stop bit is discarded.
    send_byte(8'h55, 1'b0);
    expect_idle("framing_idle", 120);
    check("framing_leds", {28'd0, leds}, 32'h1);

    // Next valid byte after a framing error.
    exp_q.push_back(8'h4F);
    send_and_expect(8'h4F, "echo_4F");
    check("leds_after_4F", {28'd0, leds}, 32'hF);

    // Non-command byte echoed unchanged, LEDs untouched.
    exp_q.push_back(8'h7A);
    send_and_expect(8'h7A, "echo_7A");
    check("leds_after_7A", {28'd0, leds}, 32'hF);

    // Reset in the middle of an echo frame.
    send_byte(8'h42, 1'b1);
    waited = 0;
    while (txd !== 1'b0 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("echo_42_started", {31'd0, txd}, 32'd0);
    check("leds_before_reset", {28'd0, leds}, 32'h2);
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midframe_reset_txd", {31'd0, txd}, 32'd1);
    check("midframe_reset_leds", {28'd0, leds}, 32'd0);
    repeat (3) @(negedge clk);
    exp_q.push_back(8'h3E);
    reset = 1'b0;
    expect_frame("prompt_again");
    expect_idle("idle_after_prompt_again", 40);
    check("exp_q_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
